plot_arbiter: RTL and testbench
===============================

Name: plot_arbiter

Overview:
- Shares the single VGA adapter pixel-write port (x, y, colour, plot) between N_REQ independent box draw/erase engines.
- Round-robin arbitration with burst locking: a granted requester keeps the port until it flags its last pixel or hits MAX_BURST. The next requester then wins.
- Sits between the per-object datapath/control pairs and the VGA adapter. Outputs are registered and drive the adapter directly.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- MAX_BURST, 16, maximum pixels granted per ownership (one 4x4 box)
- X_SCREENSIZE, 160, visible width in pixels
- Y_SCREENSIZE, 120, visible height in pixels

Ports:
- iClock  in  1  system clock
- iResetn  in  1  asynchronous active-low reset
- iReq  in  N_REQ  requester i has a valid pixel this cycle
- iLast  in  N_REQ  pixel from requester i is the final pixel of its burst
- iX  in  8*N_REQ  packed x coordinates; requester i uses bits [8i+7:8i]
- iY  in  7*N_REQ  packed y coordinates; requester i uses bits [7i+6:7i]
- iColour  in  3*N_REQ  packed colours; requester i uses bits [3i+2:3i]
- oGrant  out  N_REQ  combinational; one-hot or zero; pixel i consumed this cycle
- oX  out  8  registered pixel x
- oY  out  7  registered pixel y
- oColour  out  3  registered pixel colour
- oPlot  out  1  registered write strobe to the adapter
- oBusy  out  1  high while in BURST
- oOwner  out  3  index of the current or last owner

Behaviour:
- Reset is asynchronous, taking effect immediately with no clock edge required. It applies at power-up and mid-burst alike; any burst in progress is dropped and no pixel is emitted.
- Reset values: oX=0, oY=0, oColour=0, oPlot=0, oBusy=0, oOwner=0.
- Internal reset values: state=IDLE, round-robin pointer ptr=N_REQ-1, burst count=0.
- The state machine has two states, IDLE and BURST.
- IDLE:
  - The winner w is the first asserted iReq searching ptr+1, ptr+2, ... modulo N_REQ.
  - If any request is present: oGrant[w]=1 and owner<=w. On the next edge, count<=1. If iLast[w] is set or MAX_BURST==1, the block releases; otherwise it goes to BURST.
  - With no requests: no grant and no state change.
- BURST:
  - If iReq[owner]=1: oGrant[owner]=1 and count<=count+1.
  - The block releases when iLast[owner] is set or count+1==MAX_BURST. iLast and the MAX_BURST limit in the same cycle produce a single release.
  - If iReq[owner]=0: no grant this cycle, the lock is released, and the block goes to IDLE. No other requester is granted in that cycle.
  - Requests from non-owners are ignored until the block releases.
- Release: state<=IDLE, ptr<=owner, count<=0. The next IDLE cycle arbitrates normally. A released owner that still requests is lowest priority.
- Output latency is 1 cycle:
  - On each edge, oPlot<=|oGrant.
  - When a grant is present, oX/oY/oColour are loaded from the granted slice.
  - With no grant, oX/oY/oColour hold their previous values.
- At most one grant per cycle, so at most one pixel per clock. Maximum throughput is 1 pixel/clock.
- Coordinates are passed through unmodified unless the optional feature below is compiled in.
- oOwner updates on every grant. oBusy is high exactly while state==BURST.

Optional Feature:
- Macro: PLOT_ARBITER_CLIP_EN.
- When defined:
  - A granted pixel with x>=X_SCREENSIZE or y>=Y_SCREENSIZE is still consumed (oGrant asserted, count advances) but produces oPlot=0 on the next cycle.
  - A 16-bit saturating counter oClipCount (extra output port, reset 0) increments on each clipped pixel.
- When not defined: no range check, no oClipCount port, and all granted pixels are plotted.

Decomposition:
- A shared package vga_pkg holds:
  - constants X_SCREENSIZE, Y_SCREENSIZE
  - widths X_W=8, Y_W=7, COLOUR_W=3
  - arbiter state enum {ARB_IDLE, ARB_BURST}
- One sub-module is natural: rr_pick. It is the combinational round-robin priority search, taking the request vector and ptr and returning the winner index and a found flag. The FSM, counter and output registers stay in plot_arbiter.

Test Plan:
- Single requester:
  - Stimulus: iReq[0] held 16 cycles, iLast on the 16th pixel, x=10..13 and y=5..8 sweep.
  - Required: oGrant[0] on 16 consecutive cycles; oPlot high for 16 cycles delayed by 1; oX/oY match with 1-cycle lag; oBusy falls after the last pixel.
- Fairness:
  - Stimulus: all 4 requesters continuously requesting, never iLast, MAX_BURST=16.
  - Required: ownership order 0,1,2,3,0, with exactly 16 grants each.
- Lock:
  - Stimulus: requester 2 owns, requester 1 asserts mid-burst.
  - Required: requester 1 gets no grant until requester 2's iLast; requester 1 is granted in the first IDLE cycle after.
- Drop:
  - Stimulus: owner 3 deasserts iReq after 5 pixels.
  - Required: no grant that cycle, then IDLE; next winner searched from index 0; oPlot low for exactly 1 cycle.
- Reset mid-burst:
  - Stimulus: assert iResetn=0 between edges during a burst.
  - Required: oPlot=0 and oBusy=0 immediately, before the next edge; after release, requester 0 wins first.
- Clip (with PLOT_ARBITER_CLIP_EN):
  - Stimulus: pixel x=160, y=50.
  - Required: granted, oPlot stays 0, oClipCount=1; a following pixel x=159 is plotted.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA screen constants, pixel field widths and arbiter state encoding
package vga_pkg;
  localparam int X_SCREENSIZE = 160;
  localparam int Y_SCREENSIZE = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOUR_W = 3;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search for the first request after ptr
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       win,
  output logic             found
);
  // scan farthest-to-nearest so the nearest request after ptr is the last write
  always_comb begin
    win = ptr;
    found = |req;
    for (int k = N_REQ; k >= 1; k--)
      if (req[(int'(ptr) + k) % N_REQ]) win = 3'((int'(ptr) + k) % N_REQ);
  end
endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin burst-locked sharing of the VGA pixel port; PLOT_ARBITER_CLIP_EN adds off-screen clipping
module plot_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MAX_BURST = 16
`ifdef PLOT_ARBITER_CLIP_EN
  , parameter int X_SCREENSIZE = vga_pkg::X_SCREENSIZE,
  parameter int Y_SCREENSIZE = vga_pkg::Y_SCREENSIZE
`endif
) (
  input  logic                      iClock,
  input  logic                      iResetn,
  input  logic [N_REQ-1:0]          iReq,
  input  logic [N_REQ-1:0]          iLast,
  input  logic [X_W*N_REQ-1:0]      iX,
  input  logic [Y_W*N_REQ-1:0]      iY,
  input  logic [COLOUR_W*N_REQ-1:0] iColour,
  output logic [N_REQ-1:0]          oGrant,
  output logic [X_W-1:0]            oX,
  output logic [Y_W-1:0]            oY,
  output logic [COLOUR_W-1:0]       oColour,
  output logic                      oPlot,
  output logic                      oBusy,
  output logic [2:0]                oOwner
`ifdef PLOT_ARBITER_CLIP_EN
  , output logic [15:0]             oClipCount
`endif
);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_e state_q, state_d;
  logic [2:0] ptr_q, ptr_d, owner_q, owner_d, win, gi;
  logic [CW-1:0] count_q, count_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic plot_q, plot_d, found, gv, rel;
`ifdef PLOT_ARBITER_CLIP_EN
  logic clip;
  logic [15:0] clip_q, clip_d;
  assign oClipCount = clip_q;
`endif
  rr_pick #(.N_REQ(N_REQ)) u_pick (.req(iReq), .ptr(ptr_q), .win(win), .found(found));
  assign oX = x_q;
  assign oY = y_q;
  assign oColour = colour_q;
  assign oPlot = plot_q;
  assign oBusy = state_q == ARB_BURST;
  assign oOwner = owner_q;
  // the owner holds the port in BURST; a missing owner request, its last pixel or the burst cap all release
  always_comb begin
    gi = state_q == ARB_BURST ? owner_q : win;
    gv = state_q == ARB_BURST ? iReq[owner_q] : found;
    oGrant = gv ? (N_REQ)'(1) << gi : '0;
    rel = (gv || state_q == ARB_BURST) && (!gv || iLast[gi] || count_q + 1'b1 == CW'(MAX_BURST));
    owner_d = gv ? gi : owner_q;
    state_d = rel ? ARB_IDLE : gv ? ARB_BURST : state_q;
    ptr_d = rel ? gi : ptr_q;
    count_d = rel ? '0 : gv ? count_q + 1'b1 : count_q;
    x_d = gv ? iX[X_W*gi +: X_W] : x_q;
    y_d = gv ? iY[Y_W*gi +: Y_W] : y_q;
    colour_d = gv ? iColour[COLOUR_W*gi +: COLOUR_W] : colour_q;
`ifdef PLOT_ARBITER_CLIP_EN
    clip = gv && (int'(x_d) >= X_SCREENSIZE || int'(y_d) >= Y_SCREENSIZE);
    plot_d = gv && !clip;
    clip_d = clip && clip_q != '1 ? clip_q + 1'b1 : clip_q;
`else
    plot_d = gv;
`endif
  end
  // state, pointer, burst count and registered pixel outputs
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q <= ARB_IDLE;
      ptr_q <= 3'(N_REQ - 1);
      owner_q <= '0;
      count_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
      plot_q <= 1'b0;
`ifdef PLOT_ARBITER_CLIP_EN
      clip_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      count_q <= count_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
      plot_q <= plot_d;
`ifdef PLOT_ARBITER_CLIP_EN
      clip_q <= clip_d;
`endif
    end
  end
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed scoreboard bench for plot_arbiter (default build)
module tb_plot_arbiter;
  logic clk = 1'b0, rst_n;
  logic [3:0] req, last, grant;
  logic [31:0] bx;
  logic [27:0] by;
  logic [11:0] bc;
  logic [7:0] ox;
  logic [6:0] oy;
  logic [2:0] oc, owner;
  logic plot, busy, prev_g;
  int pass_n = 0, total_n = 0;
  logic [20:0] exp_q[$];
  logic [20:0] e;
  always #5 clk = ~clk;
  plot_arbiter #(.N_REQ(4), .MAX_BURST(16)) dut (
    .iClock(clk), .iResetn(rst_n), .iReq(req), .iLast(last), .iX(bx), .iY(by), .iColour(bc),
    .oGrant(grant), .oX(ox), .oY(oy), .oColour(oc), .oPlot(plot), .oBusy(busy), .oOwner(owner)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(posedge clk) begin
    #1;
    if (plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_n++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d owner=%0d with nothing expected at %0t", ox, oy, owner, $time);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", {11'b0, ox, oy, oc, owner}, {11'b0, e});
      end
    end
  end
  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic [3:0] eg, input logic eb);
    req = r;
    last = l;
    @(negedge clk);
    chk("grant", {28'b0, grant}, {28'b0, eg});
    chk("busy", {31'b0, busy}, {31'b0, eb});
    chk("plot", {31'b0, plot}, {31'b0, prev_g});
    for (int i = 0; i < 4; i++)
      if (eg[i]) exp_q.push_back({bx[8*i +: 8], by[7*i +: 7], bc[3*i +: 3], 3'(i)});
    prev_g = |eg;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_plot", {31'b0, plot}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = '0;
    last = '0;
    prev_g = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    req = '0;
    last = '0;
    prev_g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bx[8*i +: 8] = 8'(20 + 3*i);
      by[7*i +: 7] = 7'(30 + 5*i);
      bc[3*i +: 3] = 3'(i + 1);
    end
    #1;
    chk("rst_plot", {31'b0, plot}, 32'd0);
    chk("rst_x", {24'b0, ox}, 32'd0);
    chk("rst_y", {25'b0, oy}, 32'd0);
    chk("rst_colour", {29'b0, oc}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_owner", {29'b0, owner}, 32'd0);
    chk("rst_grant", {28'b0, grant}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bx[7:0] = 8'(10 + k % 4);
      by[6:0] = 7'(5 + k / 4);
      bc[2:0] = 3'(k);
      cyc(4'b0001, k == 15 ? 4'b0001 : 4'b0000, 4'b0001, k != 0);
    end
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
    pulse_reset();
    for (int n = 0; n < 80; n++)
      cyc(4'b1111, 4'b0000, 4'b0001 << ((n / 16) % 4), (n % 16) != 0);
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0100, 1'b0);
    for (int k = 0; k < 3; k++) cyc(4'b0110, 4'b0000, 4'b0100, 1'b1);
    cyc(4'b0110, 4'b0100, 4'b0100, 1'b1);
    cyc(4'b0110, 4'b0010, 4'b0010, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc(4'b1000, 4'b0000, 4'b1000, 1'b0);
    for (int k = 0; k < 4; k++) cyc(4'b1000, 4'b0000, 4'b1000, 1'b1);
    cyc(4'b0001, 4'b0000, 4'b0000, 1'b1);
    cyc(4'b0011, 4'b0000, 4'b0001, 1'b0);
    cyc(4'b0011, 4'b0001, 4'b0001, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0100, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0100, 1'b1);
    cyc(4'b0100, 4'b0000, 4'b0100, 1'b1);
    #2;
    pulse_reset();
    cyc(4'b0101, 4'b0001, 4'b0001, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #2;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
